// File: rtl/gerador_estado.sv
// gerador_estado: four-phase timing generator with a warning strobe, phase-00
// shortening request and an acknowledge handshake toward the change-pulse
// detector. A missing acknowledge parks the block in a sticky error state.
module gerador_estado #(
  parameter int W           = 8,
  parameter int TEMPO0      = 20,
  parameter int TEMPO1      = 5,
  parameter int TEMPO2      = 20,
  parameter int TEMPO3      = 5,
  parameter int AVISO       = 15,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       casoEsp,
  input  logic       pulso,
  output logic [1:0] estado,
  output logic       sinal,
  output logic       sinal15,
  output logic       ocupado,
  output logic       erro
);

  typedef enum logic [1:0] {
    CONTA      = 2'b00,
    ESPERA_ACK = 2'b01,
    ERRO       = 2'b10
  } fsm_t;

  localparam logic [W-1:0] UM       = W'(1);
  localparam logic [W-1:0] AVISO_W  = W'(AVISO);
  localparam logic [W-1:0] TOUT_W   = W'(ACK_TIMEOUT);
  localparam bit           AVISO_ON = (AVISO != 0);

  fsm_t       fsm;
  logic [W-1:0] cont;
  logic [W-1:0] tout;
  logic [1:0]   proxEstado;
  logic [W-1:0] contMenos1;
  logic         encurta;

  // Duration loaded into the phase counter when a given phase begins.
  function automatic logic [W-1:0] tempoDe(input logic [1:0] fase);
    logic [W-1:0] t;
    t = W'(TEMPO0);
    case (fase)
      2'b00:   t = W'(TEMPO0);
      2'b01:   t = W'(TEMPO1);
      2'b10:   t = W'(TEMPO2);
      default: t = W'(TEMPO3);
    endcase
    return t;
  endfunction

  assign proxEstado = estado + 2'd1;
  assign contMenos1 = cont - UM;
  // The shortening request only matters in phase 00 while more than the
  // warning count is left; otherwise it would lengthen or repeat the warning.
  assign encurta    = casoEsp && (estado == 2'b00) && (cont > AVISO_W);

  // Main controller: phase timing, strobes, acknowledge wait and error trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm     <= CONTA;
      estado  <= 2'b00;
      cont    <= W'(TEMPO0);
      tout    <= '0;
      sinal   <= 1'b0;
      sinal15 <= 1'b0;
      ocupado <= 1'b0;
      erro    <= 1'b0;
    end else begin
      sinal   <= 1'b0;
      sinal15 <= 1'b0;
      case (fsm)
        CONTA: begin
          if (encurta) begin
            cont    <= AVISO_W;
            sinal15 <= AVISO_ON;
          end else if (tick) begin
            if (cont == UM) begin
              estado  <= proxEstado;
              sinal   <= 1'b1;
              cont    <= tempoDe(proxEstado);
              tout    <= '0;
              fsm     <= ESPERA_ACK;
              ocupado <= 1'b1;
            end else begin
              cont    <= contMenos1;
              sinal15 <= AVISO_ON && (contMenos1 == AVISO_W);
            end
          end
        end
        ESPERA_ACK: begin
          if (pulso) begin
            fsm     <= CONTA;
            ocupado <= 1'b0;
          end else if (tick) begin
            if ((tout + UM) == TOUT_W) begin
              fsm     <= ERRO;
              ocupado <= 1'b0;
              erro    <= 1'b1;
            end else begin
              tout <= tout + UM;
            end
          end
        end
        ERRO: begin
          erro    <= 1'b1;
          ocupado <= 1'b0;
        end
        default: begin
          fsm     <= ERRO;
          erro    <= 1'b1;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gerador_estado.sv
// tb_gerador_estado: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_gerador_estado;

  localparam int AVISO       = 15;
  localparam int ACK_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       casoEsp = 1'b0;
  logic       pulso = 1'b0;
  logic [1:0] estado;
  logic       sinal;
  logic       sinal15;
  logic       ocupado;
  logic       erro;

  int checks = 0;
  int failures = 0;

  int tempoTab [0:3] = '{20, 5, 20, 5};

  // Model state: phase, ticks left, mode (0 counting, 1 waiting, 2 error).
  int mPhase = 0;
  int mLeft = 20;
  int mMode = 0;
  int mWaited = 0;
  bit mSinal = 0;
  bit mSinal15 = 0;
  bit modelOn = 0;

  gerador_estado dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .casoEsp(casoEsp),
    .pulso(pulso),
    .estado(estado),
    .sinal(sinal),
    .sinal15(sinal15),
    .ocupado(ocupado),
    .erro(erro)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0;
    mLeft = tempoTab[0];
    mMode = 0;
    mWaited = 0;
    mSinal = 0;
    mSinal15 = 0;
  endtask

  task automatic modelStep();
    mSinal = 0;
    mSinal15 = 0;
    if (mMode == 0) begin
      if (casoEsp && mPhase == 0 && mLeft > AVISO) begin
        mLeft = AVISO;
        mSinal15 = (AVISO != 0);
      end else if (tick) begin
        mLeft = mLeft - 1;
        if (mLeft == 0) begin
          mPhase = (mPhase + 1) % 4;
          mLeft = tempoTab[mPhase];
          mSinal = 1;
          mMode = 1;
          mWaited = 0;
        end else if (mLeft == AVISO && AVISO != 0) begin
          mSinal15 = 1;
        end
      end
    end else if (mMode == 1) begin
      if (pulso) begin
        mMode = 0;
      end else if (tick) begin
        mWaited = mWaited + 1;
        if (mWaited == ACK_TIMEOUT) mMode = 2;
      end
    end
  endtask

  // Advance the model on every edge the DUT reacts to, then compare outputs.
  always @(posedge clk or posedge reset) begin
    if (reset) modelReset();
    else if (modelOn) modelStep();
    #1;
    if (modelOn) begin
      checkOutput("cmp_estado", estado, mPhase);
      checkOutput("cmp_sinal", sinal, mSinal);
      checkOutput("cmp_sinal15", sinal15, mSinal15);
      checkOutput("cmp_ocupado", ocupado, mMode == 1);
      checkOutput("cmp_erro", erro, mMode == 2);
    end
  end

  task automatic applyStimulus(input bit t, input bit c, input bit p);
    @(negedge clk);
    tick = t;
    casoEsp = c;
    pulso = p;
    @(posedge clk);
    #2;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    tick = 0;
    casoEsp = 0;
    pulso = 0;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_estado", estado, 0);
    checkOutput("rst_sinal", sinal, 0);
    checkOutput("rst_sinal15", sinal15, 0);
    checkOutput("rst_ocupado", ocupado, 0);
    checkOutput("rst_erro", erro, 0);
    #1 reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0);
  endtask

  initial begin
    modelReset();
    modelOn = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("init_estado", estado, 0);
    checkOutput("init_erro", erro, 0);

    // Mid-phase reset
    ticks(7);
    checkOutput("t1_estado_mid", estado, 0);
    pulseReset();

    // Phase 00 with warning, expiry and acknowledge
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1, 0, 0);
      if (k == 5) checkOutput("t2_sinal15_at5", sinal15, 1);
      if (k == 6) checkOutput("t2_sinal15_at6", sinal15, 0);
      if (k == 19) checkOutput("t2_sinal_at19", sinal, 0);
      if (k == 20) begin
        checkOutput("t2_sinal_at20", sinal, 1);
        checkOutput("t2_estado_01", estado, 1);
        checkOutput("t2_ocupado", ocupado, 1);
      end
    end
    applyStimulus(0, 0, 1);
    checkOutput("t2_ocupado_ack", ocupado, 0);

    // Phase 01 with casoEsp held: no effect, no warning
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 1, 0);
      checkOutput("t4_no_sinal15", sinal15, 0);
      if (k == 5) begin
        checkOutput("t4_sinal", sinal, 1);
        checkOutput("t4_estado_10", estado, 2);
      end
    end
    applyStimulus(0, 0, 1);
    ticks(20);
    applyStimulus(0, 0, 1);
    ticks(5);
    checkOutput("t4_wrap_estado", estado, 0);
    checkOutput("t4_wrap_sinal", sinal, 1);
    applyStimulus(0, 0, 1);

    // casoEsp after tick 2 of phase 00
    ticks(2);
    applyStimulus(0, 1, 0);
    checkOutput("t3_sinal15", sinal15, 1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1, 0, 0);
      if (k == 1) checkOutput("t3_sinal15_off", sinal15, 0);
      if (k == 14) checkOutput("t3_sinal_at14", sinal, 0);
      if (k == 15) begin
        checkOutput("t3_sinal_at15", sinal, 1);
        checkOutput("t3_estado_01", estado, 1);
      end
    end
    applyStimulus(0, 0, 1);

    // Acknowledge timeout from phase 10
    ticks(5);
    checkOutput("t5_estado_10", estado, 2);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 0);
      if (k == 3) begin
        checkOutput("t5_erro_before", erro, 0);
        checkOutput("t5_ocupado_before", ocupado, 1);
      end
      if (k == 4) begin
        checkOutput("t5_erro", erro, 1);
        checkOutput("t5_ocupado", ocupado, 0);
      end
    end
    for (int k = 0; k < 6; k++) applyStimulus(1, 1, 1);
    checkOutput("t5_erro_sticky", erro, 1);
    checkOutput("t5_estado_frozen", estado, 2);
    pulseReset();

    // pulso coincident with the timeout tick
    ticks(20);
    ticks(3);
    applyStimulus(1, 0, 1);
    checkOutput("t6_erro", erro, 0);
    checkOutput("t6_ocupado", ocupado, 0);
    ticks(5);
    checkOutput("t6_next_sinal", sinal, 1);
    checkOutput("t6_next_estado", estado, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) pulseReset();
      else applyStimulus($urandom_range(1) == 1, $urandom_range(9) == 0, $urandom_range(2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
